// File: rtl/multicycle_control_fsm.sv
// Main control FSM for a multicycle RV32-subset datapath: decodes the opcode,
// sequences the datapath muxes/enables and counts retired instructions.
module multicycle_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic             reg_src,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       imm_src,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    state_t cur, nxt;
    logic   retire;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= S_FETCH;
            illegal <= 1'b0;
            instret <= '0;
        end else begin
            cur <= nxt;
            if (cur == S_DECODE && nxt == S_HALT)
                illegal <= 1'b1;
            if (retire)
                instret <= instret + CNT_W'(1);
        end
    end

    assign state = cur;

    // Outputs are Moore on cur except the mem_ready/zero qualified writes.
    always_comb begin
        nxt        = S_FETCH;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        reg_src    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        imm_src    = 2'b00;
        case (cur)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                nxt        = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = (op == OP_JAL) ? 2'b11 : 2'b10;
                case (op)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_R:         nxt = S_EXECR;
                    OP_I:         nxt = S_EXECI;
                    OP_BEQ:       nxt = S_BEQ;
                    OP_JAL:       nxt = S_JAL;
                    OP_LUI:       nxt = S_LUI;
                    default:      nxt = S_HALT;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = op[5] ? 2'b01 : 2'b00;
                nxt       = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                nxt     = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                retire    = mem_ready;
                nxt       = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                nxt       = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                nxt       = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = zero;
                retire    = 1'b1;
            end
            S_JAL: begin
                // JAL writes rd = PC+4 through ALUWB, so it does not retire here.
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                nxt       = S_ALUWB;
            end
            S_LUI: begin
                reg_write = 1'b1;
                reg_src   = 1'b1;
                imm_src   = 2'b11;
                retire    = 1'b1;
            end
            S_HALT: nxt = S_HALT;
            default: nxt = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-cycle expected output snapshots are
// queued as stimulus is driven and compared against the DUT on the falling edge.
module tb_multicycle_control_fsm;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic [3:0]       st;
    logic             mem_req;
    logic             mem_write;
    logic             adr_src;
    logic             ir_write;
    logic             pc_write;
    logic             reg_write;
    logic             reg_src;
    logic [1:0]       result_src;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       imm_src;
    logic             illegal;
    logic [CNT_W-1:0] instret;
  } obs_t;

  localparam int W = $bits(obs_t);

  localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4,
                         MW = 4'd5, ER = 4'd6, EI = 4'd7, AW = 4'd8, BQ = 4'd9,
                         JL = 4'd10, LU = 4'd11, HT = 4'd12;

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_LUI = 7'b0110111, OP_BAD = 7'b1111111;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [6:0]       op = 7'd0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, reg_src;
  logic [1:0]       result_src, alu_src_a, alu_src_b, alu_op, imm_src;
  logic [3:0]       state;
  logic             illegal;
  logic [CNT_W-1:0] instret;

  logic [W-1:0]     exp_q[$];
  int               n_compared = 0;
  int               n_mismatched = 0;
  logic             exp_ill = 1'b0;
  logic [CNT_W-1:0] exp_ret = '0;
  int               cyc_no = 0;

  multicycle_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .reg_src(reg_src), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src),
    .state(state), .illegal(illegal), .instret(instret)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected outputs per state, written from the control table.
  function automatic logic [W-1:0] expect_word(input logic [3:0] es, input logic mr,
                                               input logic z, input logic [6:0] o);
    obs_t e;
    e = '0;
    e.st = es;
    e.illegal = exp_ill;
    e.instret = exp_ret;
    case (es)
      F:   begin e.mem_req = 1; e.alu_src_b = 2; e.result_src = 2; e.ir_write = mr; e.pc_write = mr; end
      D:   begin e.alu_src_a = 1; e.alu_src_b = 1; e.imm_src = (o == OP_JAL) ? 2'd3 : 2'd2; end
      MA:  begin e.alu_src_a = 2; e.alu_src_b = 1; e.imm_src = o[5] ? 2'd1 : 2'd0; end
      MR:  begin e.mem_req = 1; e.adr_src = 1; end
      MWB: begin e.result_src = 1; e.reg_write = 1; end
      MW:  begin e.mem_req = 1; e.mem_write = 1; e.adr_src = 1; end
      ER:  begin e.alu_src_a = 2; e.alu_op = 2; end
      EI:  begin e.alu_src_a = 2; e.alu_src_b = 1; e.alu_op = 2; end
      AW:  begin e.reg_write = 1; end
      BQ:  begin e.alu_src_a = 2; e.alu_op = 1; e.pc_write = z; end
      JL:  begin e.alu_src_a = 1; e.alu_src_b = 2; e.pc_write = 1; end
      LU:  begin e.reg_write = 1; e.reg_src = 1; e.imm_src = 3; end
      default: ;
    endcase
    return e;
  endfunction

  // driver tasks: one call per clock cycle
  task automatic cyc(input logic r, input logic mr, input logic z, input logic [3:0] es);
    @(posedge clk);
    #1;
    rst = r;
    mem_ready = mr;
    zero = z;
    exp_q.push_back(expect_word(es, mr, z, op));
  endtask

  // mem_ready/zero are don't-care here and get randomised.
  task automatic cyc_n(input logic [3:0] es);
    cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), es);
  endtask

  task automatic alu_instr(input logic [6:0] o, input logic [3:0] ex);
    op = o;
    cyc(1'b0, 1'b1, 1'b0, F);
    cyc_n(D);
    cyc_n(ex);
    cyc_n(AW);
    exp_ret++;
  endtask

  // scoreboard
  always @(negedge clk) begin
    obs_t got;
    if (exp_q.size() != 0) begin
      got = '{state, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
              reg_src, result_src, alu_src_a, alu_src_b, alu_op, imm_src,
              illegal, instret};
      cyc_no++;
      check($sformatf("cyc%0d", cyc_no), got, exp_q.pop_front());
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    // reset state, fetch with three wait cycles, then lw
    op = OP_LW;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, F);
    cyc(1'b0, 1'b1, 1'b0, F);
    cyc_n(D); cyc_n(MA);
    cyc(1'b0, 1'b1, 1'b0, MR);
    cyc_n(MWB);
    exp_ret++;
    // sw with two memory wait cycles
    op = OP_SW;
    cyc(1'b0, 1'b1, 1'b0, F);
    cyc_n(D); cyc_n(MA);
    cyc(1'b0, 1'b0, 1'b0, MW);
    cyc(1'b0, 1'b0, 1'b0, MW);
    cyc(1'b0, 1'b1, 1'b0, MW);
    exp_ret++;
    alu_instr(OP_R, ER);
    alu_instr(OP_I, EI);
    // beq taken / not taken
    for (int t = 0; t < 2; t++) begin
      op = OP_BEQ;
      cyc(1'b0, 1'b1, 1'b0, F);
      cyc_n(D);
      cyc(1'b0, 1'($urandom_range(0, 1)), (t == 0), BQ);
      exp_ret++;
    end
    // jal
    op = OP_JAL;
    cyc(1'b0, 1'b1, 1'b0, F);
    cyc_n(D); cyc_n(JL); cyc_n(AW);
    exp_ret++;
    // lui
    op = OP_LUI;
    cyc(1'b0, 1'b1, 1'b0, F);
    cyc_n(D); cyc_n(LU);
    exp_ret++;
    // reset while a load waits on memory
    op = OP_LW;
    cyc(1'b0, 1'b1, 1'b0, F);
    cyc_n(D); cyc_n(MA);
    cyc(1'b1, 1'b0, 1'b0, MR);
    exp_ret = '0;
    cyc(1'b0, 1'b0, 1'b0, F);
    // retire 15 random ALU ops, then one more to wrap the counter
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1) alu_instr(OP_R, ER);
      else alu_instr(OP_I, EI);
    end
    // illegal opcode: HALT held, then cleared by reset
    op = OP_BAD;
    cyc(1'b0, 1'b1, 1'b0, F);
    cyc_n(D);
    exp_ill = 1'b1;
    repeat (10) cyc_n(HT);
    cyc(1'b1, 1'b0, 1'b0, HT);
    exp_ill = 1'b0;
    exp_ret = '0;
    cyc(1'b0, 1'b0, 1'b0, F);
    cyc(1'b0, 1'b0, 1'b0, F);
    @(negedge clk);
    #1;
    check("drain", W'(exp_q.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 32, width of the retired-instruction counter.
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  7  opcode field of the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  access is a store.
- adr_src  out  1  memory address source: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  load the PC.
- reg_write  out  1  register file write enable.
- reg_src  out  1  register write data: 0 = result, 1 = immediate.
- result_src  out  2  result mux: 00 = ALUOut, 01 = memory data, 10 = ALU result.
- alu_src_a  out  2  ALU A mux: 00 = PC, 01 = OldPC, 10 = RD1.
- alu_src_b  out  2  ALU B mux: 00 = RD2, 01 = immediate, 10 = constant 4.
- alu_op  out  2  00 = add, 01 = subtract/compare, 10 = funct-decoded.
- imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J/U (the extender distinguishes J from U by op).
- state  out  4  current state encoding, for debug.
- illegal  out  1  sticky flag: an unsupported opcode was decoded.
- instret  out  CNT_W  count of retired instructions.

Function
REQ-003 The state encoding SHALL be:
- FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
- EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, LUI=11, HALT=12
- Codes 13-15 SHALL transition to FETCH and drive all outputs 0.
REQ-004 Any output not listed for a state SHALL be 0 in that state.
REQ-005 FETCH outputs and transition:
- mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
- ir_write=mem_ready and pc_write=mem_ready.
- Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-006 DECODE outputs and transition:
- alu_src_a=01, alu_src_b=01, alu_op=00; imm_src=11 if op=1101111, else 10.
- Next state by op: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL; 0110111 -> LUI; any other op -> HALT.
REQ-007 MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00, imm_src=(op[5] ? 01 : 00); next is MEMWRITE if op[5]=1, else MEMREAD.
REQ-008 MEMREAD: mem_req=1, adr_src=1, result_src=00; hold until mem_ready=1, then MEMWB.
REQ-009 MEMWB: result_src=01, reg_write=1; then FETCH.
REQ-010 MEMWRITE: mem_req=1, mem_write=1, adr_src=1, result_src=00; hold until mem_ready=1, then FETCH.
REQ-011 EXECR: alu_src_a=10, alu_src_b=00, alu_op=10; then ALUWB.
REQ-012 EXECI: alu_src_a=10, alu_src_b=01, alu_op=10, imm_src=00; then ALUWB.
REQ-013 ALUWB: result_src=00, reg_write=1; then FETCH.
REQ-014 BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero; then FETCH.
REQ-015 JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1; then ALUWB, so rd receives PC+4.
REQ-016 LUI: reg_write=1, reg_src=1, imm_src=11; then FETCH.
REQ-017 HALT: all control outputs 0 and illegal=1; remain in HALT until rst.
REQ-018 illegal SHALL be set on the DECODE->HALT edge and cleared only by rst.
REQ-019 Output timing:
- All outputs SHALL be Moore functions of state, except FETCH ir_write/pc_write (combinational on mem_ready) and BEQ pc_write (combinational on zero).
REQ-020 Memory handshake rules:
- mem_req and mem_write SHALL stay stable from assertion until the cycle in which mem_ready=1.
- mem_ready SHALL be ignored in states where mem_req=0.
REQ-021 instret SHALL increment by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB, BEQ or LUI; it SHALL wrap from 2^CNT_W-1 to 0.
REQ-022 Latencies with zero-wait memory, in cycles:
- lw = 5; sw, R-type, I-type ALU and jal = 4; beq and lui = 3.
- Each wait cycle adds 1.

Reset
REQ-023 When rst=1 at a clock edge, the next state SHALL be FETCH, with instret=0 and illegal=0, regardless of the current state.
REQ-024 Reset SHALL override any pending memory wait; the cycle after reset SHALL drive FETCH outputs (mem_req=1).
REQ-025 While rst is high, the outputs SHALL reflect state FETCH from the first edge onward.

Verification
REQ-026 Fetch with mem_ready low for 3 cycles, then high -> mem_req=1 for 4 cycles; ir_write=pc_write=1 only in the 4th cycle; DECODE next.
REQ-027 op=0000011, zero-wait memory -> states 0,1,2,3,4,0; reg_write=1 with result_src=01 in state 4; instret +1.
REQ-028 op=1100011: with zero=1 -> pc_write=1 in BEQ; with zero=0 -> pc_write=0; both return to FETCH after 3 cycles.
REQ-029 op=1101111 -> states 0,1,10,8,0; DECODE imm_src=11; pc_write=1 in JAL; reg_write=1 in ALUWB.
REQ-030 op=1111111 -> HALT (state=12) with illegal=1, held for 10 cycles; rst pulse -> state=0, illegal=0, instret=0.
REQ-031 rst asserted during MEMREAD wait -> FETCH next cycle; instret preset to 2^CNT_W-1 then one ALU instruction retired -> instret=0.
